rollo_ct_packer: RTL and testbench

//  Downstream of the ROLLO-II encrypt core. After encryption finishes, reads the ciphertext

---
 rtl/rollo_pkg.sv | 29 ++
 rtl/rollo_ct_packer_if.sv | 17 +
 rtl/rollo_gearbox.sv | 73 +++++++
 rtl/rollo_ct_packer.sv | 219 +++++++++++++++++++++
 tb/tb_rollo_ct_packer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rollo_pkg.sv
// rtl/rollo_pkg.sv - shared types and constants for the ROLLO ciphertext packer
//
// Purpose : FSM state encoding, tag word count and a constant-width helper used
//           by rollo_ct_packer and rollo_gearbox.
// Ports   : none (package).
package rollo_pkg;

  // Bit width needed to index 'value' items; never returns less than 1 so that
  // degenerate parameterisations still get a legal vector.
  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    DRAIN,
    FLUSH,
    TAG,
    FIN
  } state_t;

  localparam int TAG_WORDS = 16;

endpackage

// File: rtl/rollo_ct_packer_if.sv
// rtl/rollo_ct_packer_if.sv - 32-bit valid/ready output stream of the ciphertext packer
//
// Purpose : bundles the packed output stream.
// Signals : out_data  - stream word
//           out_valid - word is presented
//           out_last  - final word of the stream
//           out_ready - consumer accepts when out_valid & out_ready
// Modports: master (packer side), slave (consumer side).
interface rollo_ct_packer_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/rollo_gearbox.sv
// rtl/rollo_gearbox.sv - shift accumulator converting IN_W-bit words to OUT_W-bit words
//
// Purpose : holds acc/cnt. A load ORs the new word in at bit offset cnt, a pop
//           drops the low OUT_W bits, a clear empties the accumulator.
// Ports   : clk, rst_b  - clock, async active-low reset
//           load_i      - place word_i at offset cnt_o
//           word_i      - IN_W-bit input word
//           pop_i       - shift out the low OUT_W bits
//           clear_i     - empty the accumulator (used after the flush word)
//           data_o      - low OUT_W bits, bits at or above cnt_o forced to zero
//           cnt_o       - number of valid bits held
module rollo_gearbox
  import rollo_pkg::*;
#(
  parameter int IN_W  = 332,
  parameter int OUT_W = 32,
  parameter int CW    = CLOG2(IN_W + OUT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load_i,
  input  logic [IN_W-1:0]  word_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [OUT_W-1:0] data_o,
  output logic [CW-1:0]    cnt_o
);

  localparam int ACC_W = IN_W + OUT_W;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] mask;

  // Loads only happen with cnt < OUT_W, so the shifted word always fits in
  // ACC_W bits. Bits above cnt are kept zero, which makes padding free.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      acc_d = acc_q | ({{OUT_W{1'b0}}, word_i} << cnt_q);
      cnt_d = cnt_q + CW'(IN_W);
    end else if (pop_i) begin
      acc_d = acc_q >> OUT_W;
      cnt_d = cnt_q - CW'(OUT_W);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Explicit pad mask so a partial final word never leaks stale bits.
  always_comb begin
    mask = '0;
    for (int j = 0; j < OUT_W; j++) begin
      mask[j] = (CW'(j) < cnt_q);
    end
  end

  assign data_o = acc_q[OUT_W-1:0] & mask;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/rollo_ct_packer.sv
// rtl/rollo_ct_packer.sv - repacks ROLLO-II ciphertext memory into a 32-bit stream
//
// Purpose : after start, reads DEPTH words of IN_W bits from the ciphertext
//           memory and emits them LSB-first as OUT_W-bit stream words, with a
//           zero-padded flush word if the bit total is not a multiple of OUT_W,
//           then pulses done.
// Macro   : ROLLO_CT_TAG_EN - when defined, a 512-bit tag sampled at start is
//           appended as 16 further words (word 0 = tag[31:0]).
// Ports   : clk, rst_b - clock, async active-low reset
//           start      - one-cycle pulse, honoured only in IDLE
//           ct_addr    - memory read address, zero whenever ct_rd is low
//           ct_rd      - read strobe
//           ct_din     - memory data, valid one cycle after ct_addr
//           tag_din    - SHA3 tag (unused without ROLLO_CT_TAG_EN)
//           out        - output stream (rollo_ct_packer_if.master)
//           busy       - high from the cycle after start until the end of done
//           done       - one-cycle pulse after the last word is accepted
module rollo_ct_packer
  import rollo_pkg::*;
#(
  parameter  int IN_W  = 332,
  parameter  int DEPTH = 48,
  parameter  int OUT_W = 32,
  localparam int AW    = CLOG2(DEPTH),
  localparam int TAG_W = TAG_WORDS * OUT_W
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                start,
  output logic [AW-1:0]       ct_addr,
  output logic                ct_rd,
  input  logic [IN_W-1:0]     ct_din,
  input  logic [TAG_W-1:0]    tag_din,
  rollo_ct_packer_if.master   out,
  output logic                busy,
  output logic                done
);

  localparam int IW = CLOG2(DEPTH + 1);
  localparam int CW = CLOG2(IN_W + OUT_W + 1);
  localparam logic [CW-1:0] W_OUT = CW'(OUT_W);
  localparam logic [IW-1:0] N_CT  = IW'(DEPTH);

  // What follows the ciphertext (and flush word): the tag words or straight
  // to FIN. LAST_CT says whether the final ciphertext word carries out_last.
`ifdef ROLLO_CT_TAG_EN
  localparam state_t TAIL_ST = TAG;
  localparam logic   LAST_CT = 1'b0;
`else
  localparam state_t TAIL_ST = FIN;
  localparam logic   LAST_CT = 1'b1;
`endif
  localparam logic TAIL_VALID = (TAIL_ST == TAG);
  localparam logic TAIL_DONE  = (TAIL_ST == FIN);

  state_t         state_q;
  logic [IW-1:0]  idx_q;
  logic [AW-1:0]  ct_addr_q;
  logic           ct_rd_q;
  logic           valid_q;
  logic           last_q;
  logic           busy_q;
  logic           done_q;

  logic             hs;
  logic             gb_load, gb_pop, gb_clear;
  logic [OUT_W-1:0] gb_data;
  logic [CW-1:0]    gb_cnt;
  logic [CW-1:0]    cnt_nx;
  logic [CW-1:0]    cnt_ld;
  logic [IW-1:0]    idx_nx;

`ifdef ROLLO_CT_TAG_EN
  localparam int TIW = CLOG2(TAG_WORDS);
  logic [TAG_W-1:0] tag_q;
  logic [TIW-1:0]   tag_idx_q;
`else
  logic unused_tag;
  assign unused_tag = ^tag_din;
`endif

  assign hs       = valid_q & out.out_ready;
  assign gb_load  = (state_q == WAIT);
  assign gb_pop   = (state_q == DRAIN) && hs;
  assign gb_clear = ((state_q == FLUSH) && hs) || (state_q == IDLE);

  // cnt after the pending pop (DRAIN only, where cnt >= OUT_W) and after the
  // pending load (WAIT only); used to decide the next word's valid/last early.
  assign cnt_nx = gb_cnt - W_OUT;
  assign cnt_ld = gb_cnt + CW'(IN_W);
  assign idx_nx = idx_q + 1'b1;

  rollo_gearbox #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .CW   (CW)
  ) u_gearbox (
    .clk    (clk),
    .rst_b  (rst_b),
    .load_i (gb_load),
    .word_i (ct_din),
    .pop_i  (gb_pop),
    .clear_i(gb_clear),
    .data_o (gb_data),
    .cnt_o  (gb_cnt)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ct_addr_q <= '0;
      ct_rd_q   <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ROLLO_CT_TAG_EN
      tag_q     <= '0;
      tag_idx_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= READ;
            busy_q    <= 1'b1;
            idx_q     <= '0;
            ct_rd_q   <= 1'b1;
            ct_addr_q <= '0;
`ifdef ROLLO_CT_TAG_EN
            tag_q     <= tag_din;
`endif
          end
        end
        READ: begin
          // Address is released as soon as the strobe drops: the top level
          // ORs the address buses of all memory clients.
          state_q   <= WAIT;
          ct_rd_q   <= 1'b0;
          ct_addr_q <= '0;
        end
        WAIT: begin
          state_q <= DRAIN;
          idx_q   <= idx_nx;
          valid_q <= 1'b1;
          last_q  <= LAST_CT && (idx_nx == N_CT) && (cnt_ld == W_OUT);
        end
        DRAIN: begin
          if (hs) begin
            if (cnt_nx >= W_OUT) begin
              last_q <= LAST_CT && (idx_q == N_CT) && (cnt_nx == W_OUT);
            end else if (idx_q < N_CT) begin
              state_q   <= READ;
              valid_q   <= 1'b0;
              last_q    <= 1'b0;
              ct_rd_q   <= 1'b1;
              ct_addr_q <= idx_q[AW-1:0];
            end else if (cnt_nx != '0) begin
              state_q <= FLUSH;
              last_q  <= LAST_CT;
            end else begin
              state_q <= TAIL_ST;
              valid_q <= TAIL_VALID;
              last_q  <= 1'b0;
              done_q  <= TAIL_DONE;
            end
          end
        end
        FLUSH: begin
          if (hs) begin
            state_q <= TAIL_ST;
            valid_q <= TAIL_VALID;
            last_q  <= 1'b0;
            done_q  <= TAIL_DONE;
          end
        end
`ifdef ROLLO_CT_TAG_EN
        TAG: begin
          if (hs) begin
            tag_q <= tag_q >> OUT_W;
            if (tag_idx_q == TIW'(TAG_WORDS - 1)) begin
              state_q   <= FIN;
              valid_q   <= 1'b0;
              last_q    <= 1'b0;
              done_q    <= 1'b1;
              tag_idx_q <= '0;
            end else begin
              tag_idx_q <= tag_idx_q + 1'b1;
              last_q    <= (tag_idx_q == TIW'(TAG_WORDS - 2));
            end
          end
        end
`endif
        FIN: begin
          // start is not looked at here, so a pulse coincident with done is dropped.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ROLLO_CT_TAG_EN
  assign out.out_data = (state_q == TAG) ? tag_q[OUT_W-1:0] : gb_data;
`else
  assign out.out_data = gb_data;
`endif
  assign out.out_valid = valid_q;
  assign out.out_last  = last_q;
  assign ct_addr       = ct_addr_q;
  assign ct_rd         = ct_rd_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_rollo_ct_packer.sv
// tb/tb_rollo_ct_packer.sv - scoreboard bench for rollo_ct_packer
//
// Purpose : drives a small (IN_W=40, DEPTH=3) and a default packer, pushes the
//           expected stream words into queues and lets per-DUT monitors pop and
//           compare every accepted word.
module tb_rollo_ct_packer;
  import rollo_pkg::*;

  localparam int IN_W  = 332;
  localparam int DEPTH = 48;
  localparam int NCT   = 498;
`ifdef ROLLO_CT_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int NTAG = TAG_EN ? TAG_WORDS : 0;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic start_d = 1'b0, start_s = 1'b0;
  logic rnd_ready = 1'b0;

  logic [5:0]      addr_d;
  logic            rd_d, busy_d, done_d;
  logic [IN_W-1:0] din_d;
  logic [1:0]      addr_s;
  logic            rd_s, busy_s, done_s;
  logic [39:0]     din_s;
  logic [511:0]    tag_din, tag_a;

  logic [IN_W-1:0] mem_d [DEPTH];
  logic [39:0]     mem_s [4];

  rollo_ct_packer_if if_d ();
  rollo_ct_packer_if if_s ();

  rollo_ct_packer u_dut (
    .clk(clk), .rst_b(rst_b), .start(start_d), .ct_addr(addr_d), .ct_rd(rd_d),
    .ct_din(din_d), .tag_din(tag_din), .out(if_d), .busy(busy_d), .done(done_d)
  );

  rollo_ct_packer #(.IN_W(40), .DEPTH(3)) u_small (
    .clk(clk), .rst_b(rst_b), .start(start_s), .ct_addr(addr_s), .ct_rd(rd_s),
    .ct_din(din_s), .tag_din(tag_din), .out(if_s), .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    din_d <= mem_d[addr_d];
    din_s <= mem_s[addr_s];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboards and monitors ----------------
  logic [32:0] exp_d[$];
  logic [32:0] exp_s[$];
  int acc_d = 0, done_cnt_d = 0, last_cyc_d = -10, rd_cnt_d = 0;
  int acc_s = 0, done_cnt_s = 0, last_cyc_s = -10;
  logic        stall_d = 1'b0;
  logic [32:0] prev_d;

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_b) begin
      if (stall_d)
        chk("stall_hold", 64'({if_d.out_valid, if_d.out_last, if_d.out_data}), 64'({1'b1, prev_d}));
      if (if_d.out_valid && if_d.out_ready) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %h, expected no word", if_d.out_data);
        end else begin
          e = exp_d.pop_front();
          chk("word_data", 64'(if_d.out_data), 64'(e[31:0]));
          chk("word_last", 64'(if_d.out_last), 64'(e[32]));
        end
        acc_d++;
        if (if_d.out_last) last_cyc_d = cyc;
      end
      stall_d = if_d.out_valid && !if_d.out_ready;
      prev_d  = {if_d.out_last, if_d.out_data};
      if (done_d) begin
        done_cnt_d++;
        chk("done_latency", 64'(cyc), 64'(last_cyc_d + 1));
      end
      if (rd_d) rd_cnt_d++;
      else chk("addr_zero", 64'(addr_d), 64'd0);
    end else begin
      stall_d = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_b) begin
      if (if_s.out_valid && if_s.out_ready) begin
        if (exp_s.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL small_extra_word: got %h, expected no word", if_s.out_data);
        end else begin
          e = exp_s.pop_front();
          chk("small_data", 64'(if_s.out_data), 64'(e[31:0]));
          chk("small_last", 64'(if_s.out_last), 64'(e[32]));
        end
        acc_s++;
        if (if_s.out_last) last_cyc_s = cyc;
      end
      if (done_s) begin
        done_cnt_s++;
        chk("small_done_latency", 64'(cyc), 64'(last_cyc_s + 1));
      end
      if (!rd_s) chk("small_addr_zero", 64'(addr_s), 64'd0);
    end
  end

  // Consumer back-pressure for the default DUT.
  initial begin
    if_s.out_ready = 1'b1;
    if_d.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if_d.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- expected-stream model ----------------
  task automatic push_tags_d();
    for (int t = 0; t < NTAG; t++)
      exp_d.push_back({(t == NTAG - 1), tag_a[32*t +: 32]});
  endtask

  task automatic build_exp_d();
    logic [31:0] w;
    int i;
    exp_d.delete();
    for (int k = 0; k < NCT; k++) begin
      for (int j = 0; j < 32; j++) begin
        i = 32 * k + j;
        w[j] = mem_d[i / IN_W][i % IN_W];
      end
      exp_d.push_back({(k == NCT - 1) && !TAG_EN, w});
    end
    push_tags_d();
  endtask

  // One stream on the default DUT. abort_at > 0 resets mid-stream at that word;
  // pulse_at >= 0 pulses start again at that word; coincident pulses start with done.
  task automatic run_d(input int abort_at, input int pulse_at, input bit coincident);
    int  d0;
    int  c;
    bit  pulsed;
    bit  seen;
    d0 = done_cnt_d;
    acc_d = 0;
    rd_cnt_d = 0;
    pulsed = 1'b0;
    seen = 1'b0;
    tag_din = tag_a;
    @(posedge clk); #1 start_d = 1'b1;
    @(posedge clk); #1 start_d = 1'b0;
    tag_din = ~tag_a;
    @(negedge clk);
    chk("busy_after_start", 64'(busy_d), 64'd1);
    for (c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (done_d) begin
        seen = 1'b1;
        break;
      end
      if (abort_at > 0 && acc_d >= abort_at) begin
        @(posedge clk); #1 rst_b = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("reset_outputs", 64'({addr_d, rd_d, busy_d, done_d, if_d.out_valid,
                                    if_d.out_last, if_d.out_data}), 64'd0);
        end
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_done_on_abort", 64'(done_cnt_d - d0), 64'd0);
        chk("idle_after_abort", 64'({busy_d, if_d.out_valid}), 64'd0);
        return;
      end
      if (pulse_at >= 0 && !pulsed && acc_d >= pulse_at) begin
        start_d = 1'b1;
        pulsed = 1'b1;
      end else begin
        start_d = 1'b0;
      end
    end
    start_d = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    if (coincident) start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_after_done", 64'({busy_d, if_d.out_valid, rd_d}), 64'd0);
    end
    chk("done_count", 64'(done_cnt_d - d0), 64'd1);
    chk("word_count", 64'(acc_d), 64'(NCT + NTAG));
    chk("queue_empty", 64'(exp_d.size()), 64'd0);
    chk("read_count", 64'(rd_cnt_d), 64'(DEPTH));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] sw [4];
    int c;
    bit seen;
    tag_a = {8{64'h0123_4567_89AB_CDEF}};
    tag_din = tag_a;
    mem_s[0] = 40'hAA_0000_0001;
    mem_s[1] = 40'h55_0000_0002;
    mem_s[2] = 40'hFF_0000_0003;
    mem_s[3] = 40'h0;
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < IN_W; b++)
        mem_d[w][b] = 1'($urandom_range(0, 1));

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    chk("reset_default", 64'({addr_d, rd_d, busy_d, done_d, if_d.out_valid,
                              if_d.out_last, if_d.out_data}), 64'd0);
    chk("reset_small", 64'({addr_s, rd_s, busy_s, done_s, if_s.out_valid,
                            if_s.out_last, if_s.out_data}), 64'd0);
    @(posedge clk); #1 rst_b = 1'b1;

    // Test 1: small instance, three 40-bit words, flush-padded final word.
    sw[0] = 32'h0000_0001;
    sw[1] = 32'h0000_02AA;
    sw[2] = 32'h0003_5500;
    sw[3] = 32'h00FF_0000;
    for (int k = 0; k < 4; k++) exp_s.push_back({(k == 3) && !TAG_EN, sw[k]});
    for (int t = 0; t < NTAG; t++) exp_s.push_back({(t == NTAG - 1), tag_a[32*t +: 32]});
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    tag_din = ~tag_a;
    seen = 1'b0;
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done_s) begin
        seen = 1'b1;
        break;
      end
    end
    chk("small_done_seen", 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    chk("small_word_count", 64'(acc_s), 64'(4 + NTAG));
    chk("small_done_count", 64'(done_cnt_s), 64'd1);
    chk("small_queue_empty", 64'(exp_s.size()), 64'd0);
    chk("small_idle", 64'({busy_s, if_s.out_valid}), 64'd0);

    // Test 2: default instance, consumer always ready.
    rnd_ready = 1'b0;
    build_exp_d();
    run_d(0, -1, 1'b0);

    // Test 3: random back-pressure, same memory, same expected sequence.
    rnd_ready = 1'b1;
    build_exp_d();
    run_d(0, -1, 1'b0);

    // Test 4: reset around word 200, then a complete restart from word 0.
    build_exp_d();
    run_d(200, -1, 1'b0);
    build_exp_d();
    run_d(0, -1, 1'b0);

    // Test 5: start re-pulsed at word 10 and again coincident with done.
    rnd_ready = 1'b0;
    build_exp_d();
    run_d(0, 10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
